// File: rtl/xor32_pkg.sv
// Shared ALU definitions: word width, condition-code flag layout, function codes.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package xor32_pkg;

  // Datapath word width used by every ALU unit.
  localparam int WORD_W = 32;

  // Bit positions of the condition codes inside a packed flag vector.
  localparam int ZF_BIT = 0;
  localparam int SF_BIT = 1;
  localparam int OF_BIT = 2;
  localparam int FLAG_W = 3;

  // ALU function code for XOR, matching the Y86 xorq ifun field.
  localparam logic [3:0] ALU_FN_XOR = 4'h3;

  typedef logic [FLAG_W-1:0] flags_t;

endpackage

// File: rtl/xor32_bit.sv
// Single-bit XOR cell, replicated across the word by the xor32 generate loop.
// Latency: purely combinational.
// Backpressure: none.
module xor1_bit (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a ^ b;

endmodule

// File: rtl/xor32.sv
// Registered bitwise XOR unit with Y86 condition codes (ZF, SF, OF).
// Latency: 1 cycle from in_valid to out_valid; one result per cycle sustained.
// Backpressure: none; downstream must take ans while out_valid is high.
module xor32
  import xor32_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] ans,
  output logic             out_valid,
  output logic             zf,
  output logic             sf,
  output logic             of
);

  logic [WIDTH-1:0] xor_vec;
  flags_t           flags_d;
  flags_t           flags_q;
  logic [WIDTH-1:0] ans_q;
  logic             vld_q;

  // One XOR cell per bit builds the combinational result vector.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    xor1_bit u_bit (
      .a (a[i]),
      .b (b[i]),
      .y (xor_vec[i])
    );
  end

  // Condition codes for the candidate result; XOR never overflows.
  always_comb begin
    flags_d         = '0;
    flags_d[ZF_BIT] = (xor_vec == '0);
    flags_d[SF_BIT] = xor_vec[WIDTH-1];
    flags_d[OF_BIT] = 1'b0;
  end

  // Result and flags load only on an accepted operand pair, so idle
  // (possibly unknown) operands never reach the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ans_q   <= '0;
      flags_q <= '0;
    end else if (in_valid) begin
      ans_q   <= xor_vec;
      flags_q <= flags_d;
    end
  end

  // Valid marks a fresh result for exactly one cycle per accepted pair;
  // reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
    end else begin
      vld_q <= in_valid;
    end
  end

  assign ans       = ans_q;
  assign out_valid = vld_q;
  assign zf        = flags_q[ZF_BIT];
  assign sf        = flags_q[SF_BIT];
  assign of        = flags_q[OF_BIT];

endmodule

// File: tb/tb_xor32.sv
module tb_xor32;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] ans;
  logic        out_valid;
  logic        zf;
  logic        sf;
  logic        of;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  // Reference model state: what the outputs must show after the last edge.
  logic [31:0] m_ans = '0;
  logic        m_vld = 0;
  logic        m_zf  = 0;
  logic        m_sf  = 0;

  xor32 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .ans       (ans),
    .out_valid (out_valid),
    .zf        (zf),
    .sf        (sf),
    .of        (of)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Behavioural model: result of the operation as a signed integer, taken
  // from the inputs present at each rising edge.
  always @(posedge clk) begin
    int signed r;
    if (rst) begin
      m_ans = '0; m_vld = 0; m_zf = 0; m_sf = 0;
    end else if (in_valid) begin
      r     = int'(a) ^ int'(b);
      m_ans = r;
      m_vld = 1;
      m_zf  = (r == 0);
      m_sf  = (r < 0);
    end else begin
      m_vld = 0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_ans", ans, m_ans);
      chk("model_vld", {31'b0, out_valid}, {31'b0, m_vld});
      chk("model_zf",  {31'b0, zf}, {31'b0, m_zf});
      chk("model_sf",  {31'b0, sf}, {31'b0, m_sf});
      chk("model_of",  {31'b0, of}, 32'd0);
    end
  end

  // Apply one cycle of inputs, then settle just after the edge.
  task automatic cyc(input logic r, input logic v, input logic [31:0] aa, input logic [31:0] bb);
    rst = r; in_valid = v; a = aa; b = bb;
    @(posedge clk);
    #2;
  endtask

  task automatic expect_out(input string name, input logic [31:0] e_ans, input logic e_vld,
                            input logic e_zf, input logic e_sf);
    chk({name, "_ans"}, ans, e_ans);
    chk({name, "_vld"}, {31'b0, out_valid}, {31'b0, e_vld});
    chk({name, "_zf"},  {31'b0, zf}, {31'b0, e_zf});
    chk({name, "_sf"},  {31'b0, sf}, {31'b0, e_sf});
    chk({name, "_of"},  {31'b0, of}, 32'd0);
  endtask

  initial begin
    int unsigned sel;
    logic [31:0] ra;
    logic [31:0] rb;

    rst = 1; in_valid = 1; a = 32'hFFFF_FFFF; b = '0;

    // Reset held two cycles with live operands.
    cyc(1, 1, 32'hFFFF_FFFF, 32'h0);
    chk_en = 1;
    cyc(1, 1, 32'hFFFF_FFFF, 32'h0);
    expect_out("reset", 32'h0, 0, 0, 0);

    // Back-to-back basic patterns.
    cyc(0, 1, 32'h0000_000B, 32'h0000_0004);
    expect_out("b_0f", 32'h0000_000F, 1, 0, 0);
    cyc(0, 1, 32'h0000_000B, 32'h0000_000C);
    expect_out("b_07", 32'h0000_0007, 1, 0, 0);

    // Negative operands.
    cyc(0, 1, 32'hFFFF_FFF5, 32'h0000_000C);
    expect_out("neg1", 32'hFFFF_FFF9, 1, 0, 1);
    cyc(0, 1, -32'sd2, 32'sd13);
    expect_out("neg2", 32'hFFFF_FFF3, 1, 0, 1);
    cyc(0, 1, -32'sd2, -32'sd13);
    expect_out("neg3", 32'h0000_000D, 1, 0, 0);

    // Equal operands.
    cyc(0, 1, 32'h0000_0009, 32'h0000_0009);
    expect_out("eq9", 32'h0, 1, 1, 0);
    cyc(0, 1, 32'h8000_0000, 32'h8000_0000);
    expect_out("eq_min", 32'h0, 1, 1, 0);

    // a = 0 passes b through; all-ones inverts.
    cyc(0, 1, 32'h0, 32'h8765_4321);
    expect_out("a_zero", 32'h8765_4321, 1, 0, 1);
    cyc(0, 1, 32'hFFFF_FFFF, 32'h0F0F_1234);
    expect_out("ones", 32'hF0F0_EDCB, 1, 0, 1);

    // Hold with unknown operands, then reset wins over in_valid.
    cyc(0, 1, 32'h0000_000B, 32'h0000_0004);
    cyc(0, 0, 'x, 'x);
    expect_out("hold", 32'h0000_000F, 0, 0, 0);
    cyc(0, 0, 'x, 'x);
    expect_out("hold2", 32'h0000_000F, 0, 0, 0);
    cyc(0, 1, 32'h1234_5678, 32'h0);
    cyc(1, 1, 32'hFFFF_FFFF, 32'h1);
    expect_out("rst_prio", 32'h0, 0, 0, 0);

    // Randomised traffic with boundary-biased operands and rare resets.
    for (int i = 0; i < 1000; i++) begin
      sel = $urandom_range(0, 9);
      ra  = $urandom;
      rb  = $urandom;
      case (sel)
        0: rb = ra;
        1: ra = '0;
        2: ra = 32'hFFFF_FFFF;
        3: begin ra[31] = 1'b1; rb[31] = 1'b0; end
        default: ;
      endcase
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), ra, rb);
    end

    cyc(0, 0, '0, '0);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
